// File: rtl/alu_pkg.sv
// Shared types for the serial-shift ALU responder.
//   alu_op_t : 3-bit operation code carried on req_op
//   state_t  : responder FSM state
//   ALU_WIDTH: default operand/result width
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_SLL  = 3'd0,
        OP_SRA  = 3'd1,
        OP_SLT  = 3'd2,
        OP_SLTU = 3'd3,
        OP_ADD  = 3'd4,
        OP_SUB  = 3'd5,
        OP_AND  = 3'd6,
        OP_XOR  = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_single_cycle.sv
// Combinational part of the ALU: compares, add/sub and bitwise ops.
// Shift codes produce zero here; shifts are handled serially by the top.
//   op     : operation code (alu_op_t encoding)
//   left   : left operand
//   right  : right operand
//   result : op(left, right), compares zero-extended
module alu_single_cycle
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (alu_op_t'(op))
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(left) < $signed(right))};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, (left < right)};
            OP_ADD:  result = left + right;
            OP_SUB:  result = left - right;
            OP_AND:  result = left & right;
            OP_XOR:  result = left ^ right;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_serial_responder.sv
// Request/response ALU slave. One operation in flight at a time.
// Non-shift ops complete in one compute cycle; shifts move one bit per cycle.
//   clock, reset_n          : clock, asynchronous active-low reset
//   req_valid/req_ready     : request handshake (req_op, req_left, req_right)
//   rsp_valid/rsp_ready     : response handshake (rsp_result)
//   busy                    : high whenever the FSM is not IDLE
module alu_serial_responder
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_left,
    input  logic [WIDTH-1:0] req_right,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             busy
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;     // working shift register, doubles as result
    logic [SHAMT_W-1:0] cnt_q, cnt_d;     // remaining shift steps
    logic               sra_q, sra_d;     // 1: arithmetic right, 0: logical left
    logic [WIDTH-1:0]   alu_result;
    logic [SHAMT_W-1:0] shamt;
    logic               is_shift;

    assign shamt    = req_right[SHAMT_W-1:0];
    assign is_shift = (req_op == OP_SLL) || (req_op == OP_SRA);

    alu_single_cycle #(.WIDTH(WIDTH)) u_alu (
        .op     (req_op),
        .left   (req_left),
        .right  (req_right),
        .result (alu_result)
    );

    // Handshake outputs depend on state only, so there is no combinational
    // path from req_* to rsp_* or from rsp_ready to req_ready.
    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign rsp_result = acc_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sra_d   = sra_q;
        case (state_q)
            IDLE: begin
                // req_op is only looked at when req_valid is high
                if (req_valid) begin
                    if (is_shift) begin
                        acc_d   = req_left;
                        cnt_d   = shamt;
                        sra_d   = (req_op == OP_SRA);
                        state_d = (shamt == '0) ? DONE : SHIFT;
                    end else begin
                        acc_d   = alu_result;
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                acc_d = sra_q ? {acc_q[WIDTH-1], acc_q[WIDTH-1:1]}
                              : {acc_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) state_d = DONE;
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sra_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sra_q   <= sra_d;
        end
    end

endmodule

// File: tb/tb_alu_serial_responder.sv
module tb_alu_serial_responder;

    logic        clock = 0;
    logic        reset_n = 0;
    logic        req_valid = 0;
    logic        req_ready;
    logic [2:0]  req_op = 0;
    logic [31:0] req_left = 0;
    logic [31:0] req_right = 0;
    logic        rsp_valid;
    logic        rsp_ready = 0;
    logic [31:0] rsp_result;
    logic        busy;

    int errors = 0;
    int checks = 0;

    alu_serial_responder #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_left   (req_left),
        .req_right  (req_right),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    // Reference model: plain arithmetic on the operation definitions.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] l,
                                          input logic [31:0] r);
        int sh;
        sh = int'(r[4:0]);
        case (op)
            3'd0: return l << sh;
            3'd1: return 32'($signed(l) >>> sh);
            3'd2: return ($signed(l) < $signed(r)) ? 32'd1 : 32'd0;
            3'd3: return (l < r) ? 32'd1 : 32'd0;
            3'd4: return l + r;
            3'd5: return l - r;
            3'd6: return l & r;
            default: return l ^ r;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] r);
        return (op <= 3'd1) ? 1 + int'(r[4:0]) : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one op from IDLE, measure latency, optionally stall the response,
    // then complete the handshake and confirm return to IDLE.
    task automatic run_op(input logic [2:0] op, input logic [31:0] l, input logic [31:0] r,
                          input logic [31:0] exp, input int exp_lat, input int stall,
                          input string name);
        int lat;
        chk({name, " req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1; req_op = op; req_left = l; req_right = r;
        step();
        // later changes to the request must have no effect
        req_valid = 0; req_op = 3'($urandom); req_left = $urandom; req_right = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            step();
            lat++;
        end
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " result"}, rsp_result, exp);
        for (int i = 0; i < stall; i++) begin
            step();
            chk({name, " stall result"}, rsp_result, exp);
        end
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        chk({name, " back to idle"}, {30'd0, rsp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        vecs.push_back('{3'd0, 32'h80000000, 32'd16,       32'h00000000, 17, "sll16"});
        vecs.push_back('{3'd0, 32'h0000000F, 32'd4,        32'h000000F0, 5,  "sll4"});
        vecs.push_back('{3'd0, 32'h00000001, 32'd31,       32'h80000000, 32, "sll31"});
        vecs.push_back('{3'd0, 32'h00000003, 32'hffffffe1, 32'h00000006, 2,  "sll_upper_ignored"});
        vecs.push_back('{3'd1, 32'h7fff0003, 32'd1,        32'h3fff8001, 2,  "sra1"});
        vecs.push_back('{3'd1, 32'h80000000, 32'd8,        32'hff800000, 9,  "sra8"});
        vecs.push_back('{3'd1, 32'h80000000, 32'd0,        32'h80000000, 1,  "sra0"});
        vecs.push_back('{3'd2, 32'hffffffff, 32'h10,       32'd1,        1,  "slt_a"});
        vecs.push_back('{3'd2, 32'h10,       32'hffffffff, 32'd0,        1,  "slt_b"});
        vecs.push_back('{3'd2, 32'hfffff000, 32'hffffffff, 32'd1,        1,  "slt_c"});
        vecs.push_back('{3'd3, 32'h80000000, 32'h7fffffff, 32'd0,        1,  "sltu_a"});
        vecs.push_back('{3'd3, 32'hff,       32'h80000000, 32'd1,        1,  "sltu_b"});
        vecs.push_back('{3'd4, 32'hffffffff, 32'd1,        32'd0,        1,  "add_wrap"});
        vecs.push_back('{3'd5, 32'd10,       32'd20,       32'hfffffff6, 1,  "sub"});
        vecs.push_back('{3'd6, 32'hf0f0ff00, 32'h0ff0f0f0, 32'h00f0f000, 1,  "and"});
        vecs.push_back('{3'd7, 32'hff00ff00, 32'h0ff00ff0, 32'hf0f0f0f0, 1,  "xor"});

        // reset state
        #12;
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset rsp_result", rsp_result, 32'd0);
        reset_n = 1;
        step();

        // directed table
        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].l, vecs[i].r, vecs[i].exp, vecs[i].lat, 0, vecs[i].name);

        // backpressure: response held, req_valid pulse ignored
        begin
            int lat;
            req_valid = 1; req_op = 3'd4; req_left = 32'hffffffff; req_right = 32'd1;
            step();
            req_valid = 0;
            lat = 1;
            while (!rsp_valid && lat < 100) begin step(); lat++; end
            chk("bp latency", lat, 1);
            for (int i = 0; i < 5; i++) begin
                if (i == 2) begin
                    req_valid = 1; req_op = 3'd7; req_left = 32'h1234; req_right = 32'h1;
                end else begin
                    req_valid = 0;
                end
                chk("bp rsp_valid", {31'd0, rsp_valid}, 32'd1);
                chk("bp result", rsp_result, 32'd0);
                chk("bp req_ready", {31'd0, req_ready}, 32'd0);
                step();
            end
            req_valid = 0;
            rsp_ready = 1;
            step();
            rsp_ready = 0;
            chk("bp idle req_ready", {31'd0, req_ready}, 32'd1);
            chk("bp idle rsp_valid", {31'd0, rsp_valid}, 32'd0);
            step();
            chk("bp pulse ignored", {31'd0, busy}, 32'd0);
        end

        // reset mid-shift
        req_valid = 1; req_op = 3'd0; req_left = 32'h1; req_right = 32'd31;
        step();
        req_valid = 0;
        repeat (9) step();
        chk("midshift busy", {31'd0, busy}, 32'd1);
        reset_n = 0;
        #1;
        chk("async rst busy", {31'd0, busy}, 32'd0);
        chk("async rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        step();
        reset_n = 1;
        for (int i = 0; i < 35; i++) begin
            chk("post rst no rsp", {31'd0, rsp_valid}, 32'd0);
            step();
        end
        run_op(3'd7, 32'hff00ff00, 32'h0ff00ff0, 32'hf0f0f0f0, 1, 0, "xor after rst");

        // back-to-back issue with req_valid and rsp_ready held high
        begin
            logic [2:0]  ops[3];
            logic [31:0] exps[3];
            int acc_cyc[$];
            logic [31:0] res[$];
            int idx;
            ops = '{3'd5, 3'd6, 3'd5};
            exps = '{32'hfffffff6, 32'h00000000, 32'hfffffff6};
            idx = 0;
            req_valid = 1; rsp_ready = 1; req_op = ops[0]; req_left = 32'd10; req_right = 32'd20;
            for (int cyc = 0; cyc < 12; cyc++) begin
                logic fire, rfire;
                fire = req_valid && req_ready;
                rfire = rsp_valid;
                if (rfire) res.push_back(rsp_result);
                if (fire) acc_cyc.push_back(cyc);
                step();
                if (fire) begin
                    idx++;
                    if (idx < 3) req_op = ops[idx];
                    else req_valid = 0;
                end
            end
            rsp_ready = 0;
            chk("b2b accept count", acc_cyc.size(), 3);
            chk("b2b result count", res.size(), 3);
            for (int i = 1; i < 3; i++)
                if (i < acc_cyc.size()) chk("b2b interval", acc_cyc[i] - acc_cyc[i-1], 2);
            for (int i = 0; i < 3; i++)
                if (i < res.size()) chk("b2b result", res[i], exps[i]);
        end
        step();

        // randomized ops against the reference model
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  op;
            logic [31:0] l, r;
            op = 3'($urandom);
            l  = $urandom;
            r  = $urandom;
            if ($urandom_range(0, 3) == 0) r = l;
            run_op(op, l, r, model(op, l, r), model_lat(op, r), $urandom_range(0, 2), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
